// File: rtl/tl_controller.sv
// -----------------------------------------------------------------------------
// tl_controller
//
// Traffic-light sequencer for one car/pedestrian crossing. It drives an
// external down-counter. On every state entry it issues a one-cycle load with
// that state's dwell value. It advances when the counter reports zero outside
// a load cycle. Every output is a flop.
//
// Optional feature macro: TL_NIGHT_BLINK_EN
//   Adds the night_i input and a BLINK state in which the car yellow lamp
//   flashes. When the macro is undefined, the behaviour matches the macro
//   build with night_i tied low.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   ped_btn_i    pedestrian button (asynchronous, active-high)
//   night_i      night-mode request (asynchronous, macro build only)
//   zero_i       counter zero flag
//   load_o       counter load strobe (one cycle per state entry)
//   duration_o   dwell value for the counter (holds between loads)
//   car_*_o      car lamps
//   ped_red_o    pedestrian red lamp
//   ped_green_o  pedestrian green lamp
//   ped_wait_o   pedestrian request pending
// -----------------------------------------------------------------------------
module tl_controller #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] GREEN_T  = 16'd24999,
    parameter logic [WIDTH-1:0] YELLOW_T = 16'd9999,
    parameter logic [WIDTH-1:0] CLEAR_T  = 16'd4999,
    parameter logic [WIDTH-1:0] WALK_T   = 16'd19999,
    parameter logic [WIDTH-1:0] BLINK_T  = 16'd2499
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ped_btn_i,
`ifdef TL_NIGHT_BLINK_EN
    input  logic             night_i,
`endif
    input  logic             zero_i,
    output logic             load_o,
    output logic [WIDTH-1:0] duration_o,
    output logic             car_red_o,
    output logic             car_yellow_o,
    output logic             car_green_o,
    output logic             ped_red_o,
    output logic             ped_green_o,
    output logic             ped_wait_o
);

    typedef enum logic [2:0] {
        ST_GREEN     = 3'd0,
        ST_YELLOW    = 3'd1,
        ST_RED_CLEAR = 3'd2,
        ST_WALK      = 3'd3,
        ST_PED_CLEAR = 3'd4
`ifdef TL_NIGHT_BLINK_EN
        ,ST_BLINK    = 3'd5
`endif
    } state_e;

    // Lamp vector order: {car_red, car_yellow, car_green, ped_red, ped_green}
    localparam logic [4:0] LAMPS_GREEN   = 5'b00110;
    localparam logic [4:0] LAMPS_YELLOW  = 5'b01010;
    localparam logic [4:0] LAMPS_ALL_RED = 5'b10010;
    localparam logic [4:0] LAMPS_WALK    = 5'b10001;

    // Dwell value loaded into the counter on entry to a state.
    function automatic logic [WIDTH-1:0] dwell_of(input state_e s);
        logic [WIDTH-1:0] d;
        case (s)
            ST_GREEN:     d = GREEN_T;
            ST_YELLOW:    d = YELLOW_T;
            ST_RED_CLEAR: d = CLEAR_T;
            ST_WALK:      d = WALK_T;
            ST_PED_CLEAR: d = CLEAR_T;
`ifdef TL_NIGHT_BLINK_EN
            ST_BLINK:     d = BLINK_T;
`endif
            default:      d = CLEAR_T;
        endcase
        return d;
    endfunction

    state_e           state_q, state_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] dur_q, dur_d;
    logic [4:0]       lamps_q, lamps_d;
    logic             req_q, req_d;
    logic             btn_meta_q, btn_sync_q, btn_prev_q;
    logic             btn_rise_s;
    logic             dwell_end_s;
    logic             req_clr_s;

`ifdef TL_NIGHT_BLINK_EN
    logic             night_meta_q, night_sync_q;
    logic             night_flag_q, night_flag_d;
    logic             blink_on_q, blink_on_d;
`else
    logic             unused_blink_t_s;
    assign unused_blink_t_s = ^BLINK_T;
`endif

    // The counter still shows its previous value during the load cycle.
    // zero_i is therefore only trusted when no load is in flight.
    assign dwell_end_s = zero_i & ~load_q;
    assign btn_rise_s  = btn_sync_q & ~btn_prev_q;

    // Next state, counter load, request latch and lamp decode.
    always_comb begin
        state_d   = state_q;
        load_d    = 1'b0;
        dur_d     = dur_q;
        req_d     = req_q;
        req_clr_s = 1'b0;
        lamps_d   = LAMPS_ALL_RED;
`ifdef TL_NIGHT_BLINK_EN
        night_flag_d = night_flag_q;
        blink_on_d   = blink_on_q;
`endif

        if (dwell_end_s) begin
            case (state_q)
                ST_GREEN: begin
`ifdef TL_NIGHT_BLINK_EN
                    night_flag_d = night_sync_q;
                    if (req_q || night_sync_q) begin
`else
                    if (req_q) begin
`endif
                        state_d = ST_YELLOW;
                    end else begin
                        state_d = ST_GREEN;
                    end
                end
                ST_YELLOW:    state_d = ST_RED_CLEAR;
                ST_RED_CLEAR: begin
`ifdef TL_NIGHT_BLINK_EN
                    if (night_flag_q) begin
                        state_d    = ST_BLINK;
                        blink_on_d = 1'b1;
                    end else begin
                        state_d = ST_WALK;
                    end
`else
                    state_d = ST_WALK;
`endif
                end
                ST_WALK:      state_d = ST_PED_CLEAR;
                ST_PED_CLEAR: state_d = ST_GREEN;
`ifdef TL_NIGHT_BLINK_EN
                ST_BLINK: begin
                    if (night_sync_q) begin
                        state_d    = ST_BLINK;
                        blink_on_d = ~blink_on_q;
                    end else begin
                        state_d = ST_PED_CLEAR;
                    end
                end
`endif
                default:      state_d = ST_PED_CLEAR;
            endcase
            // Every dwell end is a state entry, including a re-entry.
            load_d    = 1'b1;
            dur_d     = dwell_of(state_d);
            req_clr_s = (state_d == ST_WALK);
        end else begin
            state_d   = state_q;
            load_d    = 1'b0;
            dur_d     = dur_q;
            req_clr_s = 1'b0;
        end

`ifdef TL_NIGHT_BLINK_EN
        // Requests are discarded while blinking.
        req_clr_s = req_clr_s | (state_q == ST_BLINK) | (state_d == ST_BLINK);
`endif

        // On WALK entry the clear wins over a simultaneous button edge.
        if (req_clr_s) begin
            req_d = 1'b0;
        end else if (btn_rise_s) begin
            req_d = 1'b1;
        end else begin
            req_d = req_q;
        end

        case (state_d)
            ST_GREEN:     lamps_d = LAMPS_GREEN;
            ST_YELLOW:    lamps_d = LAMPS_YELLOW;
            ST_RED_CLEAR: lamps_d = LAMPS_ALL_RED;
            ST_WALK:      lamps_d = LAMPS_WALK;
            ST_PED_CLEAR: lamps_d = LAMPS_ALL_RED;
`ifdef TL_NIGHT_BLINK_EN
            ST_BLINK:     lamps_d = {1'b0, blink_on_d, 3'b000};
`endif
            default:      lamps_d = LAMPS_ALL_RED;
        endcase
    end

    // State, counter handshake, lamps, request latch and button synchronizer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_PED_CLEAR;
            load_q     <= 1'b1;
            dur_q      <= CLEAR_T;
            lamps_q    <= LAMPS_ALL_RED;
            req_q      <= 1'b0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            dur_q      <= dur_d;
            lamps_q    <= lamps_d;
            req_q      <= req_d;
            btn_meta_q <= ped_btn_i;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

`ifdef TL_NIGHT_BLINK_EN
    // Night request synchronizer, captured night flag and blink phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            night_meta_q <= 1'b0;
            night_sync_q <= 1'b0;
            night_flag_q <= 1'b0;
            blink_on_q   <= 1'b0;
        end else begin
            night_meta_q <= night_i;
            night_sync_q <= night_meta_q;
            night_flag_q <= night_flag_d;
            blink_on_q   <= blink_on_d;
        end
    end
`endif

    assign load_o       = load_q;
    assign duration_o   = dur_q;
    assign car_red_o    = lamps_q[4];
    assign car_yellow_o = lamps_q[3];
    assign car_green_o  = lamps_q[2];
    assign ped_red_o    = lamps_q[1];
    assign ped_green_o  = lamps_q[0];
    assign ped_wait_o   = req_q;

endmodule
